// File: rtl/mem_bus_arbiter.sv
`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif
// mem_bus_arbiter: shares the single memory port between dcache and icache,
// tracks which cache owns each outstanding load tag and steers returns to it.
module mem_bus_arbiter #(
  parameter int NUM_MEM_TAGS = `NUM_MEM_TAGS,
  parameter int MAX_D_STREAK = 4,
  localparam int TAG_W = $clog2(NUM_MEM_TAGS),
  localparam int CNT_W = $clog2(MAX_D_STREAK + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       d_command,
  input  logic [31:0]      d_addr,
  input  logic [63:0]      d_wdata,
  input  logic             rollback,
  input  logic [1:0]       i_command,
  input  logic [31:0]      i_addr,
  output logic [TAG_W-1:0] d_response,
  output logic [TAG_W-1:0] d_tag,
  output logic [63:0]      d_rdata,
  output logic [TAG_W-1:0] i_response,
  output logic [TAG_W-1:0] i_tag,
  output logic [63:0]      i_rdata,
  output logic [1:0]       proc2mem_command,
  output logic [31:0]      proc2mem_addr,
  output logic [63:0]      proc2mem_data,
  input  logic [TAG_W-1:0] mem2proc_response,
  input  logic [TAG_W-1:0] mem2proc_tag,
  input  logic [63:0]      mem2proc_data,
  output logic [TAG_W-1:0] d_outstanding,
  output logic [TAG_W-1:0] i_outstanding
);

  // Bus command encoding: 0 none, 1 load, 2 store.
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  localparam int         TBL_N    = 1 << TAG_W;

  logic             d_req, i_req, sel_i, sel_d;
  logic             accept, ret_hit, ret_owner;
  logic [TBL_N-1:0] valid_q, valid_d, owner_q, owner_d;
  logic [CNT_W-1:0] streak_q, streak_d;
  logic [TAG_W-1:0] d_out_q, d_out_d, i_out_q, i_out_d;

  assign d_req = d_command != BUS_NONE;
  assign i_req = i_command == BUS_LOAD;
  assign sel_i = i_req & (~d_req | (streak_q == CNT_W'(MAX_D_STREAK)));
  assign sel_d = d_req & ~sel_i;

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (sel_i) begin
      proc2mem_command = BUS_LOAD;
      proc2mem_addr    = i_addr;
    end else if (sel_d) begin
      proc2mem_command = d_command;
      proc2mem_addr    = d_addr;
      proc2mem_data    = d_wdata;
    end
  end

  assign d_response = sel_d ? mem2proc_response : '0;
  assign i_response = sel_i ? mem2proc_response : '0;

  assign accept    = (proc2mem_command == BUS_LOAD) && (mem2proc_response != '0);
  assign ret_hit   = (mem2proc_tag != '0) && valid_q[mem2proc_tag];
  assign ret_owner = owner_q[mem2proc_tag];

  // owner bit: 1 = icache, 0 = dcache
  assign d_tag   = (ret_hit && !ret_owner && !rollback) ? mem2proc_tag : '0;
  assign i_tag   = (ret_hit && ret_owner) ? mem2proc_tag : '0;
  assign d_rdata = mem2proc_data;
  assign i_rdata = mem2proc_data;

  // Accept is applied last so a tag re-issued in its return cycle stays live.
  always_comb begin
    valid_d = valid_q;
    owner_d = owner_q;
    if (rollback) valid_d = valid_q & owner_q;
    if (ret_hit) valid_d[mem2proc_tag] = 1'b0;
    if (accept) begin
      valid_d[mem2proc_response] = 1'b1;
      owner_d[mem2proc_response] = sel_i;
    end
    for (int t = 0; t < TBL_N; t++) begin
      if (t == 0 || t >= NUM_MEM_TAGS) begin
        valid_d[t] = 1'b0;
        owner_d[t] = 1'b0;
      end
    end
  end

  always_comb begin
    d_out_d = '0;
    i_out_d = '0;
    for (int t = 0; t < TBL_N; t++) begin
      if (valid_d[t] && owner_d[t])  i_out_d = i_out_d + TAG_W'(1);
      if (valid_d[t] && !owner_d[t]) d_out_d = d_out_d + TAG_W'(1);
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (!i_req || (sel_i && mem2proc_response != '0)) begin
      streak_d = '0;
    end else if (sel_d && mem2proc_response != '0 &&
                 streak_q != CNT_W'(MAX_D_STREAK)) begin
      streak_d = streak_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q  <= '0;
      owner_q  <= '0;
      streak_q <= '0;
      d_out_q  <= '0;
      i_out_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      d_out_q  <= d_out_d;
      i_out_q  <= i_out_d;
    end
  end

  assign d_outstanding = d_out_q;
  assign i_outstanding = i_out_q;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single processor–memory port between the dcache controller and the icache controller. Each cycle it grants one bus requester and forwards its command combinationally to memory. It records which requester owns each outstanding load tag and steers returning `mem2proc_tag`/`mem2proc_data` to that owner. It sits between both cache controllers and the memory model, and replaces the direct wiring of either controller to memory.

## Interface

**Parameters**
- `NUM_MEM_TAGS`, default `` `NUM_MEM_TAGS `` (15): memory tag count. Tag 0 means "no tag"; `TAG_W = $clog2(NUM_MEM_TAGS)`.
- `MAX_D_STREAK`, default 4: maximum number of consecutive accepted dcache transfers while the icache is waiting. `CNT_W = $clog2(MAX_D_STREAK+1)`.

**Ports**
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `d_command` in BUS_COMMAND: dcache request (BUS_NONE/LOAD/STORE).
- `d_addr` in 32: dcache request address.
- `d_wdata` in 64: dcache store data.
- `rollback` in 1: squash all outstanding dcache loads.
- `i_command` in BUS_COMMAND: icache request (BUS_NONE/LOAD only).
- `i_addr` in 32: icache request address.
- `d_response` out TAG_W: accept tag to dcache; 0 means not granted or not accepted.
- `d_tag` out TAG_W: returning tag routed to dcache; 0 when none.
- `d_rdata` out 64: `mem2proc_data` passthrough.
- `i_response` out TAG_W: accept tag to icache.
- `i_tag` out TAG_W: returning tag routed to icache.
- `i_rdata` out 64: `mem2proc_data` passthrough.
- `proc2mem_command` out BUS_COMMAND: command to memory.
- `proc2mem_addr` out 32: address to memory.
- `proc2mem_data` out 64: store data to memory.
- `mem2proc_response` in TAG_W: memory accept tag.
- `mem2proc_tag` in TAG_W: memory return tag.
- `mem2proc_data` in 64: memory return data.
- `d_outstanding` out TAG_W: count of valid dcache-owned tags.
- `i_outstanding` out TAG_W: count of valid icache-owned tags.

## Operation

**Grant (combinational, from registered state)**
- `d_req = d_command != BUS_NONE`; `i_req = i_command == BUS_LOAD`.
- `sel_i = i_req & (!d_req | streak == MAX_D_STREAK)`.
- Otherwise dcache is selected if `d_req`. With no request, outputs BUS_NONE, addr 0, data 0.
- Selected requester's command/addr/data are driven to `proc2mem_*`. `proc2mem_data` is `d_wdata` for dcache and 0 for icache.
- Selected requester's `*_response = mem2proc_response`. The non-selected requester's `*_response = 0`. Requesters hold their command until they see a nonzero response.

**Owner table (`valid[t]`, `owner[t]`, t = 1..NUM_MEM_TAGS-1)**
- Accept = selected command is BUS_LOAD and `mem2proc_response != 0`. On accept: `valid[resp] <= 1` and `owner[resp] <= sel_i`.
- Accepted stores are not recorded.
- Return: if `mem2proc_tag != 0` and `valid[tag]`, route the tag to the owner's `*_tag` and give the other requester 0. Then `valid[tag] <= 0`.
- A return of an invalid or unknown tag is dropped: both `*_tag = 0`.
- Same tag returned and re-accepted in the same cycle: the set wins, and the entry holds the new owner.
- `rollback`: clear every entry that is valid and dcache-owned at this edge, and suppress `d_tag` combinationally this cycle. A dcache load accepted in the same cycle is still recorded.
- `*_outstanding` = population count of valid entries per owner, registered.

**Streak counter**
- Increments (saturating at MAX_D_STREAK) on an accepted dcache transfer while `i_req`.
- Clears on an icache accept, or in any cycle with `!i_req`.
- Holds otherwise.

## Timing
- Request to `proc2mem_*`: 0 cycles, combinational.
- Response to requester: 0 cycles.
- Return routing: 0 cycles.
- Table, counter and outstanding counts update on the rising edge following the event.
- On reset assertion, immediately: all `valid = 0`, streak 0, `*_outstanding = 0`. Combinational outputs with no commands: `proc2mem_command = BUS_NONE`, all tags/responses 0. Outstanding loads in flight at reset are forgotten, and their returns are dropped.
- Worst-case icache wait under continuous dcache traffic is MAX_D_STREAK accepted dcache transfers.

## Test plan
- Only `i_command = LOAD` at 0x100, memory response 3; tag 3 returns 20 cycles later -> `i_response = 3`, then `i_tag = 3` with data, `d_tag = 0`, `i_outstanding` goes 1 then 0.
- `d_command` and `i_command` both LOAD, memory accepts every cycle with tags 1..6 -> dcache gets 4 accepts, icache gets the 5th, dcache resumes. `i_response = 0` during the dcache grants.
- `d_command = STORE` addr 0x200, data 0xDEADBEEF_00000001, response 2 -> `proc2mem_data` matches, and no table entry is created (`d_outstanding` stays 0).
- Dcache loads outstanding on tags 4 and 5, icache load on tag 6; `rollback` pulsed -> returns of 4 and 5 give `d_tag = 0`, return of 6 gives `i_tag = 6`.
- `mem2proc_response = 0` for 3 cycles with dcache requesting -> command held, no table update, streak unchanged.
- `reset` low mid-flight with 3 outstanding tags -> counts 0 asynchronously; later returns dropped; `proc2mem_command = BUS_NONE`.
